// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXE_R, EXE_I, ALU_WB, MEM_ADR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, ERROR
  } state_t;

  // Selects how alu_decoder interprets funct3/funct7b5
  typedef enum logic [1:0] {
    ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_R, ALU_CLS_I
  } alu_cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7b5 and the
// instruction class chosen by the control FSM.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  alu_cls_t   cls_i,
  output logic [3:0] op_o
);

  // funct7b5 selects SUB only for register-register ops; on I-type it is immediate bits
  always_comb begin
    op_o = ALU_ADD;
    case (cls_i)
      ALU_CLS_SUB: op_o = ALU_SUB;
      ALU_CLS_R, ALU_CLS_I: begin
        case (funct3_i)
          3'b000:  op_o = (cls_i == ALU_CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  op_o = ALU_SLL;
          3'b010:  op_o = ALU_SLT;
          3'b100:  op_o = ALU_XOR;
          3'b101:  op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  op_o = ALU_OR;
          3'b111:  op_o = ALU_AND;
          default: op_o = ALU_ADD;
        endcase
      end
      default: op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/memory/writeback
// for the shared RV32I datapath, with stall-capable memory handshakes.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       negative,
  input  logic       imem_valid,
  input  logic       dmem_ack,
  output logic       ir_en,
  output logic       pc_en,
  output logic       pc_src,
  output logic [1:0] imm_src,
  output logic       s,
  output logic [3:0] Operation,
  output logic       rg_wrt_en,
  output logic [1:0] result_src,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       instr_retired,
  output logic       illegal
);

  state_t   state_q, state_d;
  alu_cls_t alu_cls;

  alu_decoder u_alu_decoder (
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .cls_i      (alu_cls),
    .op_o       (Operation)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 1'b0;
    imm_src       = IMM_I;
    s             = 1'b0;
    alu_cls       = ALU_CLS_ADD;
    rg_wrt_en     = 1'b0;
    result_src    = RES_ALU;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      FETCH: begin
        ir_en = imem_valid;
        if (imem_valid) state_d = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:               state_d = EXE_R;
          OP_I:               state_d = EXE_I;
          OP_LOAD, OP_STORE:  state_d = MEM_ADR;
          OP_BRANCH:          state_d = BRANCH;
          OP_JAL:             state_d = JAL;
          default:            state_d = ERROR;
        endcase
      end
      EXE_R: begin
        s       = 1'b1;
        alu_cls = ALU_CLS_R;
        state_d = ALU_WB;
      end
      EXE_I: begin
        alu_cls = ALU_CLS_I;
        state_d = ALU_WB;
      end
      ALU_WB: begin
        rg_wrt_en     = 1'b1;
        pc_en         = 1'b1;
        instr_retired = 1'b1;
        state_d       = FETCH;
      end
      MEM_ADR: begin
        if (opcode == OP_STORE) begin
          imm_src = IMM_S;
          state_d = MEM_WR;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_d = MEM_WB;
      end
      MEM_WB: begin
        rg_wrt_en     = 1'b1;
        result_src    = RES_MEM;
        pc_en         = 1'b1;
        instr_retired = 1'b1;
        state_d       = FETCH;
      end
      // A store retires in the same cycle the memory acknowledges it
      MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        imm_src  = IMM_S;
        if (dmem_ack) begin
          pc_en         = 1'b1;
          instr_retired = 1'b1;
          state_d       = FETCH;
        end
      end
      BRANCH: begin
        s             = 1'b1;
        alu_cls       = ALU_CLS_SUB;
        imm_src       = IMM_B;
        pc_en         = 1'b1;
        instr_retired = 1'b1;
        state_d       = FETCH;
        case (funct3)
          3'b000:  pc_src = zero;
          3'b001:  pc_src = ~zero;
          3'b100:  pc_src = negative;
          3'b101:  pc_src = ~negative;
          default: pc_src = 1'b0;
        endcase
      end
      JAL: begin
        imm_src       = IMM_J;
        rg_wrt_en     = 1'b1;
        result_src    = RES_PC4;
        pc_en         = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        state_d       = FETCH;
      end
      ERROR: illegal = 1'b1;
      default: state_d = FETCH;
    endcase
  end

endmodule
